// File: rtl/adapter_pkg.sv
// Shared widths, state encoding and data types for the cacheline burst adapter.
package adapter_pkg;

    localparam int unsigned LINE_W = 256;
    localparam int unsigned BEAT_W = 64;
    localparam int unsigned BEATS  = LINE_W / BEAT_W;

    typedef enum logic [1:0] {
        IDLE,
        RD_BURST,
        WR_BURST,
        DONE
    } adapter_state_t;

    typedef logic [LINE_W-1:0] line_t;
    typedef logic [BEAT_W-1:0] beat_t;

endpackage

// File: rtl/line_buffer.sv
// Cacheline holding register: whole-line load, per-beat load and per-beat read-out.
module line_buffer #(
    parameter int unsigned LINE_W = adapter_pkg::LINE_W,
    parameter int unsigned BEAT_W = adapter_pkg::BEAT_W,
    parameter int unsigned IDX_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_line,
    input  logic [LINE_W-1:0] line_in,
    input  logic              load_beat,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [BEAT_W-1:0] beat_in,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [BEAT_W-1:0] beat_out,
    output logic [LINE_W-1:0] line_out
);

    logic [LINE_W-1:0] line_q, line_d;

    always_comb begin
        line_d = line_q;
        if (load_line) begin
            line_d = line_in;
        end else if (load_beat) begin
            line_d[wr_idx*BEAT_W +: BEAT_W] = beat_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            line_q <= '0;
        end else begin
            line_q <= line_d;
        end
    end

    assign beat_out = line_q[rd_idx*BEAT_W +: BEAT_W];
    assign line_out = line_q;

endmodule

// File: rtl/cacheline_adapter.sv
// Converts single cacheline read/write requests into 4-beat bursts on the memory bus and
// returns assembled read lines with a one-cycle pmem_resp.
module cacheline_adapter #(
    parameter int unsigned LINE_W = adapter_pkg::LINE_W,
    parameter int unsigned BEAT_W = adapter_pkg::BEAT_W,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pmem_address,
    input  logic              pmem_read,
    input  logic              pmem_write,
    input  logic [LINE_W-1:0] pmem_wdata,
    output logic [LINE_W-1:0] pmem_rdata,
    output logic              pmem_resp,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [BEAT_W-1:0] mem_wdata,
    input  logic [BEAT_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    import adapter_pkg::*;

    localparam int unsigned NUM_BEATS = LINE_W / BEAT_W;
    localparam int unsigned IDX_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam int unsigned OFF_W     = $clog2(LINE_W / 8);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BEATS - 1);

    adapter_state_t    state_q, state_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] rdata_q, rdata_d;

    logic              load_line;
    logic              load_beat;
    logic [LINE_W-1:0] buf_line;
    logic [BEAT_W-1:0] buf_beat;
    logic              last_beat;
    logic              unused_offset_bits;

    // Byte offset within the line never reaches the memory bus.
    assign unused_offset_bits = ^pmem_address[OFF_W-1:0];

    assign last_beat = mem_resp && (cnt_q == LAST_IDX);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        rdata_d   = rdata_q;
        load_line = 1'b0;
        load_beat = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pmem_read || pmem_write) begin
                    addr_d = {pmem_address[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    cnt_d  = '0;
                    if (pmem_read) begin
                        state_d = RD_BURST;
                    end else begin
                        state_d   = WR_BURST;
                        load_line = 1'b1;
                    end
                end
            end
            RD_BURST: begin
                if (mem_resp) begin
                    load_beat = 1'b1;
                    cnt_d     = cnt_q + IDX_W'(1);
                end
                if (last_beat) begin
                    // Final beat bypasses the buffer so the line is complete in DONE.
                    rdata_d                      = buf_line;
                    rdata_d[LINE_W-1 -: BEAT_W]  = mem_rdata;
                    state_d                      = DONE;
                end
            end
            WR_BURST: begin
                if (mem_resp) begin
                    cnt_d = cnt_q + IDX_W'(1);
                end
                if (last_beat) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
        end
    end

    line_buffer #(
        .LINE_W (LINE_W),
        .BEAT_W (BEAT_W),
        .IDX_W  (IDX_W)
    ) u_line_buffer (
        .clk       (clk),
        .rst       (rst),
        .load_line (load_line),
        .line_in   (pmem_wdata),
        .load_beat (load_beat),
        .wr_idx    (cnt_q),
        .beat_in   (mem_rdata),
        .rd_idx    (cnt_q),
        .beat_out  (buf_beat),
        .line_out  (buf_line)
    );

    assign pmem_resp   = (state_q == DONE);
    assign pmem_rdata  = rdata_q;
    assign mem_read    = (state_q == RD_BURST);
    assign mem_write   = (state_q == WR_BURST);
    assign mem_address = addr_q;
    assign mem_wdata   = mem_write ? buf_beat : '0;

endmodule

// File: tb/tb_cacheline_adapter.sv
// Self-checking bench for cacheline_adapter: table of line transactions plus reset/stray cases.
module tb_cacheline_adapter;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
    logic [31:0]  mem_address;
    logic         mem_read;
    logic         mem_write;
    logic [63:0]  mem_wdata;
    logic [63:0]  mem_rdata;
    logic         mem_resp;

    cacheline_adapter dut (
        .clk          (clk),
        .rst          (rst),
        .pmem_address (pmem_address),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .mem_address  (mem_address),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_resp     (mem_resp)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    function automatic void chk(input string name, input logic [255:0] act,
                                input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Scoreboard: expected read lines (one per pmem_resp) and expected write beats.
    logic [255:0] resp_q[$];
    logic [63:0]  wbeat_q[$];
    logic [31:0]  exp_addr = '0;
    logic [255:0] last_rd  = '0;

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_read || mem_write) begin
                chk("mem_rw_exclusive", mem_read & mem_write, 0);
                chk("mem_address", mem_address, exp_addr);
                if (mem_write && mem_resp) begin
                    if (wbeat_q.size() == 0) chk("wbeat_unexpected", mem_write, 0);
                    else chk("mem_wdata", mem_wdata, wbeat_q.pop_front());
                end
            end
            if (pmem_resp) begin
                if (resp_q.size() == 0) chk("pmem_resp_unexpected", pmem_resp, 0);
                else chk("pmem_rdata", pmem_rdata, resp_q.pop_front());
            end
        end
    end

    typedef struct {
        string        name;
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] line;
        logic [15:0]  pat;       // mem_resp per burst cycle, bit 0 = first cycle
        logic [31:0]  exp_addr;
        int           exp_lat;   // accept cycle to pmem_resp cycle
    } vec_t;

    vec_t vecs[6];

    task automatic run_txn(input vec_t v);
        int unsigned start;
        int k;
        int beat;
        int busy;
        exp_addr = v.exp_addr;
        if (v.wr) begin
            for (int b = 0; b < 4; b++) wbeat_q.push_back(v.line[b*64 +: 64]);
            resp_q.push_back(last_rd);
        end else begin
            resp_q.push_back(v.line);
            last_rd = v.line;
        end
        pmem_address = v.addr;
        pmem_read    = !v.wr;
        pmem_write   = v.wr;
        pmem_wdata   = v.wr ? v.line : ~v.line;
        start = cyc;
        k = 0;
        beat = 0;
        busy = 0;
        @(posedge clk); #1;
        while (!pmem_resp && k < 40) begin
            if (mem_read || mem_write) busy++;
            mem_resp  = (k < 16) ? v.pat[k] : 1'b0;
            mem_rdata = (mem_resp && beat < 4) ? v.line[beat*64 +: 64] : {$urandom, $urandom};
            if (mem_resp) beat++;
            k++;
            @(posedge clk); #1;
        end
        mem_resp   = 1'b0;
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        chk({v.name, "_latency"}, cyc - start, v.exp_lat);
        chk({v.name, "_busy_cycles"}, busy, v.exp_lat - 1);
        @(posedge clk); #1;
        chk({v.name, "_single_resp"}, pmem_resp, 0);
        chk({v.name, "_idle_bus"}, {mem_read, mem_write}, 0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_pmem_resp"}, pmem_resp, 0);
        chk({tag, "_pmem_rdata"}, pmem_rdata, 0);
        chk({tag, "_mem_read"}, mem_read, 0);
        chk({tag, "_mem_write"}, mem_write, 0);
        chk({tag, "_mem_address"}, mem_address, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
    endtask

    initial begin
        vec_t fresh;
        logic [255:0] aborted;
        vecs[0] = '{"rd_basic", 1'b0, 32'h0000_1234,
                    {64'hA3, 64'hA2, 64'hA1, 64'hA0}, 16'hFFFF, 32'h0000_1220, 5};
        vecs[1] = '{"wr_basic", 1'b1, 32'h0000_8040,
                    {{16{4'h3}}, {16{4'h2}}, {16{4'h1}}, {16{4'h0}}}, 16'hFFFF, 32'h0000_8040, 5};
        // resp on burst cycles 1,3,4,7
        vecs[2] = '{"rd_gaps", 1'b0, 32'hDEAD_BEEF,
                    {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                     64'hDEAD_BEEF_CAFE_F00D, 64'h5A5A_5A5A_A5A5_A5A5},
                    16'h004D, 32'hDEAD_BEE0, 8};
        vecs[3] = '{"wr_b2b", 1'b1, 32'hFFFF_FFFF,
                    {64'h1111_0000_2222_0000, 64'h0F0F_0F0F_0F0F_0F0F,
                     64'h8000_0000_0000_0001, 64'hC0DE_C0DE_C0DE_C0DE},
                    16'hFFFF, 32'hFFFF_FFE0, 5};
        vecs[4] = '{"rd_b2b", 1'b0, 32'h0000_001F,
                    {64'h4444_4444_0000_0004, 64'h3333_3333_0000_0003,
                     64'h2222_2222_0000_0002, 64'h1111_1111_0000_0001},
                    16'hFFFF, 32'h0000_0000, 5};
        vecs[5] = '{"wr_gaps", 1'b1, 32'h4000_0020,
                    {64'hAAAA_BBBB_CCCC_DDDD, 64'h1234_1234_1234_1234,
                     64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_0000_0000},
                    16'h0055, 32'h4000_0020, 8};

        rst = 1'b1;
        pmem_address = '0;
        pmem_read = 1'b0;
        pmem_write = 1'b0;
        pmem_wdata = '0;
        mem_rdata = '0;
        mem_resp = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) run_txn(vecs[i]);

        // Stray mem_resp pulses while idle must be ignored.
        for (int i = 0; i < 4; i++) begin
            mem_resp  = 1'b1;
            mem_rdata = {$urandom, $urandom};
            @(posedge clk); #1;
            chk("stray_mem_read", mem_read, 0);
            chk("stray_mem_write", mem_write, 0);
            chk("stray_pmem_resp", pmem_resp, 0);
        end
        mem_resp = 1'b0;
        chk("stray_rdata_held", pmem_rdata, last_rd);
        run_txn(vecs[1]);
        chk("wr_keeps_rdata", pmem_rdata, last_rd);

        // Reset after three beats of a read: partial line discarded, no pmem_resp.
        aborted = {64'h9999, 64'h8888, 64'h7777, 64'h6666};
        exp_addr = 32'h0000_5540;
        pmem_address = 32'h0000_5550;
        pmem_read = 1'b1;
        @(posedge clk); #1;
        for (int b = 0; b < 3; b++) begin
            mem_resp  = 1'b1;
            mem_rdata = aborted[b*64 +: 64];
            @(posedge clk); #1;
        end
        chk("abort_mid_burst", mem_read, 1);
        mem_resp = 1'b0;
        pmem_read = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        check_all_zero("midreset");
        rst = 1'b0;
        last_rd = '0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("post_reset_no_resp", pmem_resp, 0);
        end
        fresh = '{"rd_fresh", 1'b0, 32'h0000_5550,
                  {64'hF3F3, 64'hF2F2, 64'hF1F1, 64'hF0F0}, 16'hFFFF, 32'h0000_5540, 5};
        run_txn(fresh);
        chk("scoreboard_drained", resp_q.size() + wbeat_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors + 1);
        $fatal(1);
    end

endmodule
